load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-stage access unit between the execute/memory pipeline register and the writeback pipeline register.
- Takes the M-stage address, store data and load/store controls, and drives a variable-latency word-wide data bus with a req/ack handshake.
- Performs byte/half/word lane steering, sign or zero extension of loads, and misalignment detection.
- Raises stall_M to the hazard unit while a bus access is outstanding.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles without bus_ack before the access is aborted with bus_err.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-low.
- rd_en_M  input  1  load in M stage.
- wr_en_M  input  1  store in M stage.
- funct3_M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_M  input  32  byte address (the M-stage ALU result).
- wdata_M  input  32  store data (the forwarded rs2 value).
- rdata_M  output  32  extended load data to the writeback pipeline register.
- stall_M  output  1  freeze F/D/E/M stages.
- misalign  output  1  one-cycle pulse: misaligned access or illegal funct3.
- bus_err  output  1  one-cycle pulse: timeout abort.
- bus_req  output  1  bus request, held until ack.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word address, {addr_M[31:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_rdata  input  32  read word, valid with bus_ack.
- bus_ack  input  1  access complete (single-cycle pulse).

Behaviour:
- Reset (rst==0 at a clk edge):
  - State becomes IDLE; counter cleared.
  - All outputs 0: rdata_M, stall_M, misalign, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata.
  - Applies mid-access too; a bus_ack arriving after reset is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access = rd_en_M | wr_en_M.
  - Illegal if any of:
    - both rd_en_M and wr_en_M are set;
    - funct3 is not in the legal set (a store allows only 000/001/010);
    - a half access has addr[0] != 0;
    - a word access has addr[1:0] != 0.
  - Legal access:
    - stall_M = 1 combinationally.
    - Next cycle: BUSY, with bus_req/bus_we/bus_addr/bus_be/bus_wdata registered and held stable until ack.
  - Illegal access: no bus activity, misalign = 1 for this cycle, stall_M = 0, rdata_M = 0.
- Byte enables and store data:
  - B: be = 1 << addr[1:0], wdata = {4{wdata_M[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{wdata_M[15:0]}}.
  - W: be = 1111, wdata = wdata_M.
  - Loads drive the same be values.
- BUSY:
  - stall_M = 1; counter increments each cycle.
  - bus_ack: capture bus_rdata, select the lane by addr[1:0], extend (B/H sign-extend, BU/HU zero-extend, W as is), register into rdata_M, drop bus_req, go to DONE.
  - Stores leave rdata_M at 0.
  - Counter reaches TIMEOUT without ack: drop bus_req, pulse bus_err, rdata_M = 0, go to DONE.
- DONE:
  - stall_M = 0 and rdata_M valid; the pipeline advances at the end of this cycle.
  - Unconditionally returns to IDLE; the inputs are not re-evaluated this cycle.
- Latency:
  - Minimum 3 cycles per access (IDLE, BUSY with ack in its first cycle, DONE).
  - Generally 2 + N cycles for ack after N BUSY cycles.
- rdata_M holds its value until the next completed load, abort or illegal access.
- bus_ack while in IDLE or DONE is ignored.
- Back-to-back accesses: a new access is accepted in the IDLE cycle following DONE.

Test Plan:
- LW addr 0x100, ack after 2 BUSY cycles, bus_rdata 0xDEADBEEF -> bus_be 1111, bus_addr 0x100, stall_M high for 3 cycles, rdata_M 0xDEADBEEF in DONE.
- LB addr 0x103 with bus_rdata 0x80FF0000 -> be 1000, rdata_M 0xFFFFFF80; LBU same access -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x206, wdata_M 0x1234ABCD -> bus_we 1, be 1100, bus_wdata 0xABCDABCD, bus_addr 0x204; SB addr 0x201 -> be 0010, bus_wdata 0xCDCDCDCD.
- LW addr 0x102, then SH addr 0x101, then wr_en with funct3 011 -> each gives misalign pulse, stall_M 0, no bus_req, rdata_M 0.
- No ack with TIMEOUT=4 -> bus_req high exactly 4 cycles, bus_err one-cycle pulse, rdata_M 0, returns to IDLE.
- rst low during BUSY, then bus_ack asserted one cycle later -> all outputs 0, state IDLE, late ack ignored; a following LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: decodes the M-stage access, drives a
// req/ack word bus, steers byte/half lanes, extends load data and flags
// misaligned or illegal accesses. Bus timeouts abort with bus_err.
module load_store_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en_M,
    input  logic        wr_en_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic [31:0] rdata_M,
    output logic        stall_M,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       f3_reg;
    logic [1:0]       off_reg;

    logic        access;
    logic        f3_legal;
    logic        align_ok;
    logic        illegal;
    logic        legal;
    logic        timeout;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_ext;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [7:0]  rbyte [4];

    // Split the returned word into its four byte lanes for steering.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = bus_rdata[8*gi +: 8];
        end
    endgenerate

    assign timeout = (cnt_reg == CNT_W'(TIMEOUT - 1));

    // Decode the M-stage request: legality, byte enables and replicated store data.
    always_comb begin
        access   = rd_en_M | wr_en_M;
        f3_legal = 1'b0;
        if (wr_en_M) begin
            f3_legal = (funct3_M == 3'b000) || (funct3_M == 3'b001) || (funct3_M == 3'b010);
        end else begin
            f3_legal = (funct3_M == 3'b000) || (funct3_M == 3'b001) || (funct3_M == 3'b010) ||
                       (funct3_M == 3'b100) || (funct3_M == 3'b101);
        end
        case (funct3_M[1:0])
            2'b01:   align_ok = (addr_M[0] == 1'b0);
            2'b10:   align_ok = (addr_M[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        illegal = access & ((rd_en_M & wr_en_M) | ~f3_legal | ~align_ok);
        legal   = access & ~illegal;
        case (funct3_M[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr_M[1:0];
                wdata_next = {4{wdata_M[7:0]}};
            end
            2'b01: begin
                be_next    = addr_M[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata_M[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata_M;
            end
        endcase
    end

    // Select and extend the addressed lane of the returned word.
    always_comb begin
        sel_byte = rbyte[off_reg];
        sel_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_reg)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DONE always returns to IDLE without looking at inputs.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (legal) state_next = BUSY;
            BUSY:    if (bus_ack || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational outputs; forced low while reset is asserted.
    always_comb begin
        stall_M  = 1'b0;
        misalign = 1'b0;
        if (rst) begin
            case (state_reg)
                IDLE: begin
                    stall_M  = legal;
                    misalign = illegal;
                end
                BUSY:    stall_M = 1'b1;
                default: stall_M = 1'b0;
            endcase
        end
    end

    // Registered bus interface, timeout counter and load result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg   <= '0;
            f3_reg    <= 3'd0;
            off_reg   <= 2'd0;
            rdata_M   <= 32'd0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            bus_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (legal) begin
                        cnt_reg   <= '0;
                        f3_reg    <= funct3_M;
                        off_reg   <= addr_M[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= wr_en_M;
                        bus_addr  <= {addr_M[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                    end else if (illegal) begin
                        rdata_M <= 32'd0;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (bus_ack || timeout) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_be    <= 4'd0;
                        bus_wdata <= 32'd0;
                        if (bus_ack) begin
                            rdata_M <= bus_we ? 32'd0 : load_ext;
                        end else begin
                            rdata_M <= 32'd0;
                            bus_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
